// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard; x0 reads as zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data and busy-clear to the read ports.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_write,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic                         i_issue,
  input  logic [ADDR_W-1:0]            i_issue_addr,
  input  logic                         i_flush,
  input  logic [RD_PORTS*ADDR_W-1:0]   i_raddr,
  output logic [RD_PORTS*DATA_W-1:0]   o_rdata,
  output logic [RD_PORTS-1:0]          o_rbusy,
  output logic [ADDR_W:0]              o_busy_count
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_busy_count;
  logic [NUM_REGS-1:0] w_busy_d;
  logic [CNT_W-1:0]    w_count_d;
  logic                w_issue_set;

  assign w_issue_set = i_issue && (i_issue_addr != '0) && !i_flush;

  // Clear on writeback first so a same-cycle issue to the same register wins.
  always_comb begin
    w_busy_d = r_busy;
    if (i_write) w_busy_d[i_waddr] = 1'b0;
    if (w_issue_set) w_busy_d[i_issue_addr] = 1'b1;
    if (i_flush) w_busy_d = '0;
    w_busy_d[0] = 1'b0;
  end

  always_comb begin
    w_count_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_count_d = w_count_d + CNT_W'(w_busy_d[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_write && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_d;
      r_busy_count <= w_count_d;
    end
  end

  assign o_busy_count = r_busy_count;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic              w_zero;
    assign w_raddr = i_raddr[p*ADDR_W +: ADDR_W];
    assign w_zero  = (w_raddr == '0);
`ifdef REG_FILE_BYPASS_EN
    logic w_fwd;
    logic w_reset_busy;
    assign w_fwd        = i_write && (i_waddr != '0) && (w_raddr == i_waddr);
    assign w_reset_busy = w_issue_set && (i_issue_addr == i_waddr);
    always_comb begin
      o_rdata[p*DATA_W +: DATA_W] = '0;
      o_rbusy[p]                  = 1'b0;
      if (!w_zero) begin
        if (w_fwd) begin
          o_rdata[p*DATA_W +: DATA_W] = i_wdata;
          o_rbusy[p]                  = w_reset_busy ? r_busy[w_raddr] : 1'b0;
        end else begin
          o_rdata[p*DATA_W +: DATA_W] = r_regs[w_raddr];
          o_rbusy[p]                  = r_busy[w_raddr];
        end
      end
    end
`else
    assign o_rdata[p*DATA_W +: DATA_W] = w_zero ? '0 : r_regs[w_raddr];
    assign o_rbusy[p]                  = w_zero ? 1'b0 : r_busy[w_raddr];
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb (2 read ports, 32x32).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue;
  logic [4:0]  issue_addr;
  logic        flush;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [5:0]  busy_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_write      (write),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_issue      (issue),
    .i_issue_addr (issue_addr),
    .i_flush      (flush),
    .i_raddr      (raddr),
    .o_rdata      (rdata),
    .o_rbusy      (rbusy),
    .o_busy_count (busy_count)
  );

  typedef struct {
    logic        write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue;
    logic [4:0]  iaddr;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] d0, input logic b0,
                               input logic [31:0] d1, input logic b1, input logic [5:0] cnt);
    check({tag, " rdata0"}, rdata[31:0], d0);
    check({tag, " rbusy0"}, {31'd0, rbusy[0]}, {31'd0, b0});
    check({tag, " rdata1"}, rdata[63:32], d1);
    check({tag, " rbusy1"}, {31'd0, rbusy[1]}, {31'd0, b1});
    check({tag, " count"}, {26'd0, busy_count}, {26'd0, cnt});
  endtask

  task automatic idle_inputs();
    write = 1'b0; waddr = '0; wdata = '0;
    issue = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  initial begin
    //            wr    waddr  wdata          iss   iaddr  fl    ra0    ra1    d0             b0    d1             b1    cnt
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 6'd0};
    vecs[1]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd7,  32'h0,        1'b1, 32'h0,        1'b0, 6'd1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd3,  5'd7,  32'h0,        1'b1, 32'h0,        1'b1, 6'd2};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd7,  32'h0,        1'b1, 32'h0,        1'b1, 6'd2};
    vecs[5]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 5'd0,  1'b0, 5'd3,  5'd7,  32'hA5A5A5A5, 1'b0, 32'h0,        1'b1, 6'd1};
    vecs[6]  = '{1'b1, 5'd9,  32'h00000055, 1'b1, 5'd9,  1'b0, 5'd9,  5'd7,  32'h00000055, 1'b1, 32'h0,        1'b1, 6'd2};
    vecs[7]  = '{1'b1, 5'd7,  32'h00001111, 1'b0, 5'd0,  1'b0, 5'd7,  5'd9,  32'h00001111, 1'b0, 32'h00000055, 1'b1, 6'd1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd9,  32'h0,        1'b1, 32'h00000055, 1'b1, 6'd2};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd2,  5'd1,  32'h0,        1'b1, 32'h0,        1'b1, 6'd3};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd2,  5'd4,  32'h0,        1'b1, 32'h0,        1'b1, 6'd4};
    vecs[11] = '{1'b1, 5'd12, 32'h00000077, 1'b1, 5'd6,  1'b1, 5'd6,  5'd12, 32'h0,        1'b0, 32'h00000077, 1'b0, 6'd0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd1,  5'd9,  32'h0,        1'b0, 32'h00000055, 1'b0, 6'd0};
    vecs[13] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 1'b0, 5'd31, 5'd4,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b0, 6'd1};

    rst = 1'b1;
    idle_inputs();
    raddr = {5'd5, 5'd0};
    #2;
    check_outputs("reset", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      write = vecs[i].write; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      issue = vecs[i].issue; issue_addr = vecs[i].iaddr; flush = vecs[i].flush;
      @(posedge clk);
      #1;
      idle_inputs();
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].d0, vecs[i].b0, vecs[i].d1, vecs[i].b1,
                    vecs[i].cnt);
    end

    // Asynchronous reset mid-cycle: x5 holds DEADBEEF, x31 is busy.
    @(negedge clk);
    raddr = {5'd31, 5'd5};
    #1;
    check_outputs("pre_rst", 32'hDEADBEEF, 1'b0, 32'hFFFFFFFF, 1'b1, 6'd1);
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    issue = 1'b1; issue_addr = 5'd10;
    raddr = {5'd10, 5'd8};
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_outputs("post_rst_issue", 32'h0, 1'b0, 32'h0, 1'b1, 6'd1);

    // Same-cycle write and read of x10 (busy) on port 1.
    @(negedge clk);
    write = 1'b1; waddr = 5'd10; wdata = 32'hCAFEF00D;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check_outputs("bypass_pre", 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 6'd1);
`else
    check_outputs("bypass_pre", 32'h0, 1'b0, 32'h0, 1'b1, 6'd1);
`endif
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_outputs("bypass_post", 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 6'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
